// File: rtl/uart_prog_loader_if.sv
// Instruction-memory write port driven by the boot loader.
// Latency: n/a (signal bundle only).
// Backpressure: none; imem must accept one write per cycle when imem_we is high.
interface uart_prog_loader_if #(
  parameter int ADDR_W = 12
);
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_din;

  modport master (output imem_we, output imem_addr, output imem_din);
  modport slave  (input  imem_we, input  imem_addr, input  imem_din);
endinterface

// File: rtl/uart_prog_loader.sv
// UART (8N1) boot loader: header N, then N little-endian words written into imem; holds the CPU in reset until done.
// Latency: byte_valid 1 clk after stop sample, imem_we 1 clk after 4th byte, cpu_rst falls 2 clks after last write.
// Backpressure: none; the UART line cannot be stalled, so every write is a single unconditional pulse.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rxd,
  uart_prog_loader_if.master imem,
  output logic               cpu_rst,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [ADDR_W:0]    words_loaded
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [32:0]      N_MAX    = 33'(1) << ADDR_W;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
  typedef enum logic [1:0] {HDR, DATA, DONE, ERR} ld_state_e;

  // ---------------- synchroniser ----------------
  logic rxd_s1_q, rxd_s2_q;

  // Two-flop synchroniser; preset to idle-high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rxd_s1_q <= 1'b1;
      rxd_s2_q <= 1'b1;
    end else begin
      rxd_s1_q <= rxd;
      rxd_s2_q <= rxd_s1_q;
    end
  end

  // ---------------- RX bit engine ----------------
  rx_state_e        rx_st_q, rx_st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_vld_q, byte_vld_d;
  logic             frm_err_q, frm_err_d;
  logic             start_ok;

  // Bit timing: confirm start mid-bit, then sample one bit period apart, LSB first.
  always_comb begin
    rx_st_d    = rx_st_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_vld_d = 1'b0;
    frm_err_d  = 1'b0;
    start_ok   = 1'b0;
    case (rx_st_q)
      R_IDLE: begin
        if (!rxd_s2_q) begin
          rx_st_d = R_START;
          cnt_d   = '0;
        end
      end
      R_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rxd_s2_q) begin
            rx_st_d  = R_DATA;
            bit_d    = '0;
            start_ok = 1'b1;
          end else begin
            rx_st_d = R_IDLE;  // short low pulse: glitch, not a frame
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxd_s2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_st_d = R_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin  // R_STOP
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          rx_st_d = R_IDLE;
          if (rxd_s2_q) byte_vld_d = 1'b1;
          else          frm_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // RX engine state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_st_q    <= R_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      byte_vld_q <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      rx_st_q    <= rx_st_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      byte_vld_q <= byte_vld_d;
      frm_err_q  <= frm_err_d;
    end
  end

  // ---------------- loader FSM ----------------
  ld_state_e         ld_st_q, ld_st_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       asm_q, asm_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d, cpu_rst_q, cpu_rst_d;
  logic [31:0]       full_word;

  // Header/word assembly, write generation and sticky status; header and data share one assembler.
  always_comb begin
    ld_st_d    = ld_st_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    n_d        = n_q;
    words_d    = words_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    din_d      = din_q;
    full_word  = {shift_q, asm_q[31:8]};
    case (ld_st_q)
      HDR: begin
        if (frm_err_q) begin
          ld_st_d = ERR;
        end else if (byte_vld_q) begin
          asm_d      = full_word;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if ({1'b0, full_word} > N_MAX) ld_st_d = ERR;
            else if (full_word == 32'd0)   ld_st_d = DONE;
            else begin
              ld_st_d = DATA;
              n_d     = full_word[ADDR_W:0];
            end
          end
        end
      end
      DATA: begin
        // Count advances the cycle after the pulse; last write hands over to DONE.
        if (we_q) begin
          words_d = words_q + 1'b1;
          if ((words_q + 1'b1) == n_q) ld_st_d = DONE;
        end
        if (frm_err_q) begin
          ld_st_d = ERR;
        end else if (byte_vld_q) begin
          asm_d      = full_word;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            we_d   = 1'b1;
            din_d  = full_word;
            addr_d = words_q[ADDR_W-1:0];
          end
        end
      end
      default: ;  // DONE and ERR are terminal until reset
    endcase

    busy_d = busy_q;
    if (ld_st_q == DONE || ld_st_q == ERR) busy_d = 1'b0;
    else if (ld_st_q == HDR && start_ok)   busy_d = 1'b1;
    done_d    = done_q | (ld_st_q == DONE);
    err_d     = err_q  | (ld_st_q == ERR);
    cpu_rst_d = cpu_rst_q & (ld_st_q != DONE);
  end

  // Loader state and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ld_st_q    <= HDR;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      n_q        <= '0;
      words_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_rst_q  <= 1'b1;
    end else begin
      ld_st_q    <= ld_st_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      n_q        <= n_d;
      words_q    <= words_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cpu_rst_q  <= cpu_rst_d;
    end
  end

  assign imem.imem_we   = we_q;
  assign imem.imem_addr = addr_q;
  assign imem.imem_din  = din_q;
  assign cpu_rst        = cpu_rst_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign words_loaded   = words_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: directed UART images against a byte-stream model of the load protocol.
`timescale 1ns/1ps
module tb_uart_prog_loader;
  localparam int CPB = 4;
  localparam int AW  = 12;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rxd = 1'b1;
  logic          cpu_rst, busy, done, err;
  logic [AW:0]   words_loaded;

  uart_prog_loader_if #(.ADDR_W(AW)) imem_if ();

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .rxd          (rxd),
    .imem         (imem_if),
    .cpu_rst      (cpu_rst),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  wr_t  exp_q[$];
  wr_t  obs_q[$];
  logic m_done, m_err;
  int   m_words;
  int   cyc = 0;
  int   last_we_cyc = -100;
  bit   had_write = 0;
  logic prev_cpu_rst = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Protocol model: header N, then N words; derive expected writes and final status from the bytes.
  task automatic model_stream(input bq_t b, input int bad);
    logic [31:0] n, w;
    int base;
    m_done = 1'b0; m_err = 1'b0; m_words = 0;
    for (int i = 0; i < 4; i++) if (i == bad) begin m_err = 1'b1; return; end
    if (b.size() < 4) return;
    n = {b[3], b[2], b[1], b[0]};
    if (n > (32'd1 << AW)) begin m_err = 1'b1; return; end
    for (int k = 0; k < int'(n); k++) begin
      base = 4 + 4 * k;
      if (bad >= base && bad < base + 4) begin m_err = 1'b1; return; end
      if (base + 3 >= b.size()) return;
      w = {b[base+3], b[base+2], b[base+1], b[base]};
      exp_q.push_back({AW'(k), w});
      m_words++;
    end
    m_done = 1'b1;
  endtask

  // All drive tasks start and end on a falling edge.
  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(v[i]);
    drive_bit(stop);
    drive_bit(1'b1);
  endtask

  task automatic send_range(input bq_t b, input int bad, input int from, input int upto);
    for (int i = from; i < upto; i++) send_byte(b[i], (i == bad) ? 1'b0 : 1'b1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.delete();
    obs_q.delete();
    chk("rst_imem_we",   imem_if.imem_we, 0);
    chk("rst_imem_addr", imem_if.imem_addr, 0);
    chk("rst_imem_din",  imem_if.imem_din, 0);
    chk("rst_cpu_rst",   cpu_rst, 1);
    chk("rst_busy",      busy, 0);
    chk("rst_done",      done, 0);
    chk("rst_err",       err, 0);
    chk("rst_words",     words_loaded, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic final_check(input string tag);
    repeat (12) @(negedge clk);
    chk({tag, "_words"},   words_loaded, m_words);
    chk({tag, "_done"},    done, m_done);
    chk({tag, "_err"},     err, m_err);
    chk({tag, "_cpu_rst"}, cpu_rst, !m_done);
    chk({tag, "_pending"}, exp_q.size(), 0);
    if (m_done || m_err) chk({tag, "_busy"}, busy, 0);
  endtask

  // Per-cycle compare: every write against the model queue, plus status invariants and release latency.
  always @(negedge clk) begin
    wr_t w, e;
    cyc++;
    if (!rst) begin
      had_write    = 0;
      prev_cpu_rst = 1'b1;
    end else begin
      if (imem_if.imem_we) begin
        w = {imem_if.imem_addr, imem_if.imem_din};
        obs_q.push_back(w);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", w.addr, w.data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", w.addr, e.addr);
          chk("wr_data", w.data, e.data);
        end
        had_write   = 1;
        last_we_cyc = cyc;
      end
      chk("cpu_rst_vs_done", cpu_rst, !done);
      if (err) chk("err_holds_cpu_rst", cpu_rst, 1);
      if (prev_cpu_rst && !cpu_rst && had_write) chk("cpu_rst_latency", cyc - last_we_cyc, 2);
      prev_cpu_rst = cpu_rst;
    end
  end

  initial begin
    bq_t s, s2;

    // Power-on reset values.
    apply_reset();

    // Two-word image.
    s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    model_stream(s, -1);
    send_range(s, -1, 0, 4);
    chk("t2_busy_mid", busy, 1);
    chk("t2_cpu_rst_mid", cpu_rst, 1);
    send_range(s, -1, 4, s.size());
    final_check("t2");
    chk("t2_lit_n",     obs_q.size(), 2);
    chk("t2_lit_a0",    obs_q[0].addr, 0);
    chk("t2_lit_d0",    obs_q[0].data, 32'h12345678);
    chk("t2_lit_a1",    obs_q[1].addr, 1);
    chk("t2_lit_d1",    obs_q[1].data, 32'hDEADBEEF);
    chk("t2_lit_words", words_loaded, 2);

    // Empty image, trailing bytes must be ignored.
    apply_reset();
    s = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    model_stream(s, -1);
    send_range(s, -1, 0, s.size());
    final_check("t3");
    chk("t3_lit_done", done, 1);
    chk("t3_lit_nwr",  obs_q.size(), 0);

    // Oversize header (4097 words).
    apply_reset();
    s = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    model_stream(s, -1);
    send_range(s, -1, 0, s.size());
    final_check("t4");
    chk("t4_lit_err", err, 1);

    // Framing error on the 2nd data byte, then a valid image that must be ignored.
    apply_reset();
    s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    model_stream(s, 5);
    send_range(s, 5, 0, s.size());
    s2 = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_range(s2, -1, 0, s2.size());
    final_check("t5");
    chk("t5_lit_err",     err, 1);
    chk("t5_lit_cpu_rst", cpu_rst, 1);

    // One-cycle glitch in idle, then a valid one-word image.
    apply_reset();
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_glitch_err",  err, 0);
    chk("t6_glitch_busy", busy, 0);
    s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    model_stream(s, -1);
    send_range(s, -1, 0, s.size());
    final_check("t6");
    chk("t6_lit_d0", obs_q[0].data, 32'hDDCCBBAA);

    // Reset in the middle of word 3 of a 5-word load, then a fresh one-word image.
    apply_reset();
    s = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
          8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00};
    model_stream(s, -1);
    send_range(s, -1, 0, s.size());
    final_check("t7a");
    chk("t7a_busy", busy, 1);
    apply_reset();
    s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h0D, 8'hF0, 8'hAD, 8'h0B};
    model_stream(s, -1);
    send_range(s, -1, 0, s.size());
    final_check("t7b");
    chk("t7b_lit_a0", obs_q[0].addr, 0);
    chk("t7b_lit_d0", obs_q[0].data, 32'h0BADF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
